packet_deparser_n6: RTL and testbench

Transmit-side counterpart of the N6 packet parser. Accepts a flow descriptor (Ethernet/IPv4/UDP-or-TCP fields plus payload length) and a 32-bit payload word stream. Emits a big-endian Ethernet/IPv4/L4 frame on the 32-bit bus, computing the IPv4 total length, UDP length and IPv4 header checksum. The frame format is the one the parser consumes: first byte on bus[31:24], start_of_packet marked on the first beat.

---
 rtl/parser_typedefs_pkg.sv | 40 ++++
 rtl/packet_deparser_n6_if.sv | 49 ++++
 rtl/packet_deparser_n6_ipv4_hdr_csum.sv | 22 ++
 rtl/packet_deparser_n6.sv | 220 ++++++++++++++++++++++
 tb/tb_packet_deparser_n6.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parser_typedefs_pkg.sv
// Shared N6 parser/deparser types: header sizes, protocol codes,
// transmit FSM states and the latched flow descriptor.
package parser_typedefs_pkg;

    localparam int ETH_HDR_B  = 14;
    localparam int IPV4_HDR_B = 20;
    localparam int UDP_HDR_B  = 8;
    localparam int TCP_HDR_B  = 20;

    localparam logic [7:0]  PROTOCOL_TCP   = 8'd6;
    localparam logic [7:0]  PROTOCOL_UDP   = 8'd17;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

    typedef enum logic [2:0] {
        IDLE,
        CSUM,
        HDR,
        PAY,
        TAIL
    } n6_tx_states_e;

    typedef struct packed {
        logic [47:0] eth_dst;
        logic [47:0] eth_src;
        logic [7:0]  tos;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] id;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [15:0] sport;
        logic [15:0] dport;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [7:0]  flags;
        logic [15:0] win;
        logic [15:0] pay_len;
    } n6_desc_t;

endpackage

// File: rtl/packet_deparser_n6_if.sv
// Descriptor, payload and frame-bus signals of the N6 deparser.
// slave is the deparser side, master the driving/sinking side.
interface packet_deparser_n6_if;
    logic        hdr_valid_i;
    logic        hdr_ready_o;
    logic [47:0] eth_dst_i;
    logic [47:0] eth_src_i;
    logic [7:0]  ip_tos_i;
    logic [7:0]  ip_ttl_i;
    logic [7:0]  ip_proto_i;
    logic [15:0] ip_id_i;
    logic [31:0] ip_src_i;
    logic [31:0] ip_dst_i;
    logic [15:0] src_port_i;
    logic [15:0] dst_port_i;
    logic [31:0] tcp_seq_i;
    logic [31:0] tcp_ack_i;
    logic [7:0]  tcp_flags_i;
    logic [15:0] tcp_win_i;
    logic [15:0] pay_len_i;
    logic [31:0] pay_i;
    logic        pay_valid_i;
    logic        pay_ready_o;
    logic [31:0] bus_o;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic        start_of_packet_o;
    logic        bus_last_o;
    logic [2:0]  bus_bytes_o;
    logic        hdr_err_o;

    modport slave (
        input  hdr_valid_i, eth_dst_i, eth_src_i, ip_tos_i, ip_ttl_i,
               ip_proto_i, ip_id_i, ip_src_i, ip_dst_i, src_port_i,
               dst_port_i, tcp_seq_i, tcp_ack_i, tcp_flags_i, tcp_win_i,
               pay_len_i, pay_i, pay_valid_i, bus_ready_i,
        output hdr_ready_o, pay_ready_o, bus_o, bus_valid_o,
               start_of_packet_o, bus_last_o, bus_bytes_o, hdr_err_o
    );

    modport master (
        output hdr_valid_i, eth_dst_i, eth_src_i, ip_tos_i, ip_ttl_i,
               ip_proto_i, ip_id_i, ip_src_i, ip_dst_i, src_port_i,
               dst_port_i, tcp_seq_i, tcp_ack_i, tcp_flags_i, tcp_win_i,
               pay_len_i, pay_i, pay_valid_i, bus_ready_i,
        input  hdr_ready_o, pay_ready_o, bus_o, bus_valid_o,
               start_of_packet_o, bus_last_o, bus_bytes_o, hdr_err_o
    );
endinterface

// File: rtl/packet_deparser_n6_ipv4_hdr_csum.sv
// IPv4 header checksum: one's-complement of the folded 16-bit sum of
// ten header words (checksum word supplied as zero).
module ipv4_hdr_csum (
    input  logic [159:0] hdr,
    output logic [15:0]  csum
);
    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        sum = '0;
        for (int i = 0; i < 10; i++) begin
            sum = sum + 20'(hdr[i*16 +: 16]);
        end
    end

    assign fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
    assign fold2 = fold1[15:0] + 16'(fold1[16]);
    assign csum  = ~fold2;

endmodule

// File: rtl/packet_deparser_n6.sv
// N6 transmit deparser: descriptor + payload words in, big-endian
// Ethernet/IPv4/UDP-or-TCP frame out on a registered 32-bit bus.
module packet_deparser_n6
    import parser_typedefs_pkg::*;
#(
    parameter int MAX_PAYLOAD_B = 1472,
    parameter int BUS_WIDTH_B   = 4
) (
    input logic                 CLK,
    input logic                 reset,
    packet_deparser_n6_if.slave io
);
    localparam int BW     = BUS_WIDTH_B * 8;
    localparam int SR_W   = (ETH_HDR_B + IPV4_HDR_B + TCP_HDR_B) * 8;
    localparam int UDP_NB = (ETH_HDR_B + IPV4_HDR_B + UDP_HDR_B) / 4;
    localparam int TCP_NB = (ETH_HDR_B + IPV4_HDR_B + TCP_HDR_B) / 4;

    n6_tx_states_e   state_q, state_d;
    n6_desc_t        desc_q, desc_d, desc_in;
    logic [SR_W-1:0] sr_q, sr_d, hdr_img;
    logic [15:0]     cnt_q, cnt_d, carry_q, carry_d;
    logic [2:0]      tail_q, tail_d;
    logic [BW-1:0]   bus_q, bus_d;
    logic            valid_q, valid_d, sop_q, sop_d, last_q, last_d;
    logic [2:0]      bytes_q, bytes_d;
    logic            hrdy_q, hrdy_d, err_q, err_d, prdy;
    logic            is_tcp, fire, bad, adv, last_word;
    logic [15:0]     tot_len, udp_len, nwords, nbeats, csum;
    logic [159:0]    ip_raw, ip_hdr;
    logic [111:0]    eth_hdr;

    assign desc_in = '{
        eth_dst: io.eth_dst_i,   eth_src: io.eth_src_i,
        tos:     io.ip_tos_i,    ttl:     io.ip_ttl_i,
        proto:   io.ip_proto_i,  id:      io.ip_id_i,
        ip_src:  io.ip_src_i,    ip_dst:  io.ip_dst_i,
        sport:   io.src_port_i,  dport:   io.dst_port_i,
        seq:     io.tcp_seq_i,   ack:     io.tcp_ack_i,
        flags:   io.tcp_flags_i, win:     io.tcp_win_i,
        pay_len: io.pay_len_i
    };

    assign is_tcp  = (desc_q.proto == PROTOCOL_TCP);
    assign tot_len = 16'(IPV4_HDR_B) + desc_q.pay_len
                   + (is_tcp ? 16'(TCP_HDR_B) : 16'(UDP_HDR_B));
    assign udp_len = 16'(UDP_HDR_B) + desc_q.pay_len;
    assign nbeats  = is_tcp ? 16'(TCP_NB) : 16'(UDP_NB);
    assign nwords  = (desc_q.pay_len + 16'd3) >> 2;

    assign ip_raw = {8'h45, desc_q.tos, tot_len, desc_q.id, 16'h4000,
                     desc_q.ttl, desc_q.proto, 16'h0000,
                     desc_q.ip_src, desc_q.ip_dst};

    ipv4_hdr_csum u_csum (
        .hdr  (ip_raw),
        .csum (csum)
    );

    assign ip_hdr  = {ip_raw[159:80], csum, ip_raw[63:0]};
    assign eth_hdr = {desc_q.eth_dst, desc_q.eth_src, ETHERTYPE_IPV4};

    // Header image is MSB-aligned; the UDP form leaves 12 unused bytes
    assign hdr_img = is_tcp
        ? {eth_hdr, ip_hdr, desc_q.sport, desc_q.dport, desc_q.seq,
           desc_q.ack, 8'h50, desc_q.flags, desc_q.win, 32'h0}
        : {eth_hdr, ip_hdr, desc_q.sport, desc_q.dport, udp_len,
           16'h0, 96'h0};

    assign fire = io.hdr_valid_i && hrdy_q;
    assign bad  = !(io.ip_proto_i == PROTOCOL_UDP ||
                    io.ip_proto_i == PROTOCOL_TCP) ||
                  (io.pay_len_i > 16'(MAX_PAYLOAD_B));
    assign adv       = !valid_q || io.bus_ready_i;
    assign last_word = (cnt_q == nwords - 16'd1);

    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        tail_d  = tail_q;
        bus_d   = bus_q;
        valid_d = valid_q;
        sop_d   = sop_q;
        last_d  = last_q;
        bytes_d = bytes_q;
        err_d   = 1'b0;
        prdy    = 1'b0;
        if (adv) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            last_d  = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        desc_d  = desc_in;
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                sr_d    = hdr_img;
                cnt_d   = '0;
                state_d = HDR;
            end
            HDR: begin
                if (adv) begin
                    valid_d = 1'b1;
                    bus_d   = sr_q[SR_W-1 -: 32];
                    sr_d    = sr_q << 32;
                    sop_d   = (cnt_q == 16'd0);
                    bytes_d = 3'd4;
                    cnt_d   = cnt_q + 16'd1;
                    if (cnt_q == nbeats - 16'd1) begin
                        // two header bytes remain and prefix the payload
                        carry_d = sr_q[SR_W-33 -: 16];
                        cnt_d   = '0;
                        if (desc_q.pay_len == 16'd0) begin
                            tail_d  = 3'd2;
                            state_d = TAIL;
                        end else begin
                            state_d = PAY;
                        end
                    end
                end
            end
            PAY: begin
                prdy = adv;
                if (adv && io.pay_valid_i) begin
                    valid_d = 1'b1;
                    bus_d   = {carry_q, io.pay_i[31:16]};
                    carry_d = io.pay_i[15:0];
                    bytes_d = 3'd4;
                    cnt_d   = cnt_q + 16'd1;
                    if (last_word) begin
                        unique case (desc_q.pay_len[1:0])
                            2'd1: begin
                                bytes_d    = 3'd3;
                                bus_d[7:0] = 8'h00;
                                last_d     = 1'b1;
                                state_d    = IDLE;
                            end
                            2'd2: begin
                                last_d  = 1'b1;
                                state_d = IDLE;
                            end
                            2'd3: begin
                                tail_d  = 3'd1;
                                state_d = TAIL;
                            end
                            default: begin
                                tail_d  = 3'd2;
                                state_d = TAIL;
                            end
                        endcase
                    end
                end
            end
            TAIL: begin
                if (adv) begin
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                    bytes_d = tail_q;
                    bus_d   = (tail_q == 3'd1) ? {carry_q[15:8], 24'h0}
                                               : {carry_q, 16'h0};
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        hrdy_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            desc_q  <= '0;
            sr_q    <= '0;
            cnt_q   <= '0;
            carry_q <= '0;
            tail_q  <= '0;
            bus_q   <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            last_q  <= 1'b0;
            bytes_q <= 3'd4;
            hrdy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            tail_q  <= tail_d;
            bus_q   <= bus_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            last_q  <= last_d;
            bytes_q <= bytes_d;
            hrdy_q  <= hrdy_d;
            err_q   <= err_d;
        end
    end

    assign io.hdr_ready_o       = hrdy_q;
    assign io.hdr_err_o         = err_q;
    assign io.pay_ready_o       = prdy;
    assign io.bus_o             = bus_q;
    assign io.bus_valid_o       = valid_q;
    assign io.start_of_packet_o = sop_q;
    assign io.bus_last_o        = last_q;
    assign io.bus_bytes_o       = bytes_q;

endmodule

// File: tb/tb_packet_deparser_n6.sv
// Randomized bench for packet_deparser_n6 against a byte-level frame
// model built from the descriptor fields.
module tb_packet_deparser_n6;
    import parser_typedefs_pkg::*;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    packet_deparser_n6_if bif ();

    packet_deparser_n6 #(
        .MAX_PAYLOAD_B (1472),
        .BUS_WIDTH_B   (4)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .io    (bif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [47:0] d_dst, d_src;
    logic [7:0]  d_tos, d_ttl, d_proto, d_flags;
    logic [15:0] d_id, d_sp, d_dp, d_win, d_len;
    logic [31:0] d_ips, d_ipd, d_seq, d_ack;

    logic [7:0]  exp_q[$];
    logic [31:0] words[$];
    logic [31:0] rx_d[$];
    int          rx_b[$];
    bit          rx_s[$];
    bit          rx_l[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rand_desc(input logic [7:0] proto, input logic [15:0] len);
        d_dst = {16'($urandom), $urandom};
        d_src = {16'($urandom), $urandom};
        d_tos = 8'($urandom);   d_ttl = 8'($urandom);
        d_id  = 16'($urandom);  d_ips = $urandom;
        d_ipd = $urandom;       d_sp  = 16'($urandom);
        d_dp  = 16'($urandom);  d_seq = $urandom;
        d_ack = $urandom;       d_flags = 8'($urandom);
        d_win = 16'($urandom);
        d_proto = proto;
        d_len   = len;
    endtask

    task automatic push_n(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
    endtask

    // Whole frame as a byte list, payload bytes drawn at random
    task automatic build_exp();
        int h4, s, hl;
        logic [15:0] tl, ck;
        exp_q.delete();
        words.delete();
        h4 = (d_proto == 8'd6) ? 20 : 8;
        tl = 16'(20 + h4 + int'(d_len));
        push_n(64'(d_dst), 6);
        push_n(64'(d_src), 6);
        push_n(64'h0800, 2);
        push_n(64'h45, 1);
        push_n(64'(d_tos), 1);
        push_n(64'(tl), 2);
        push_n(64'(d_id), 2);
        push_n(64'h4000, 2);
        push_n(64'(d_ttl), 1);
        push_n(64'(d_proto), 1);
        push_n(64'h0, 2);
        push_n(64'(d_ips), 4);
        push_n(64'(d_ipd), 4);
        s = 0;
        for (int i = 0; i < 10; i++)
            s += int'({exp_q[14 + 2*i], exp_q[15 + 2*i]});
        while (s > 65535) s = (s % 65536) + (s / 65536);
        ck = ~16'(s);
        exp_q[24] = ck[15:8];
        exp_q[25] = ck[7:0];
        push_n(64'(d_sp), 2);
        push_n(64'(d_dp), 2);
        if (h4 == 20) begin
            push_n(64'(d_seq), 4);
            push_n(64'(d_ack), 4);
            push_n(64'h50, 1);
            push_n(64'(d_flags), 1);
            push_n(64'(d_win), 2);
            push_n(64'h0, 4);
        end else begin
            push_n(64'(16'(8 + int'(d_len))), 2);
            push_n(64'h0, 2);
        end
        hl = exp_q.size();
        for (int i = 0; i < int'(d_len); i++) exp_q.push_back(8'($urandom));
        for (int w = 0; w < (int'(d_len) + 3) / 4; w++) begin
            logic [31:0] wd;
            wd = $urandom;
            for (int j = 0; j < 4; j++)
                if (4*w + j < int'(d_len)) wd[31 - 8*j -: 8] = exp_q[hl + 4*w + j];
            words.push_back(wd);
        end
    endtask

    task automatic send_desc();
        bit ok;
        @(negedge CLK);
        bif.eth_dst_i = d_dst;  bif.eth_src_i = d_src;
        bif.ip_tos_i = d_tos;   bif.ip_ttl_i = d_ttl;
        bif.ip_proto_i = d_proto; bif.ip_id_i = d_id;
        bif.ip_src_i = d_ips;   bif.ip_dst_i = d_ipd;
        bif.src_port_i = d_sp;  bif.dst_port_i = d_dp;
        bif.tcp_seq_i = d_seq;  bif.tcp_ack_i = d_ack;
        bif.tcp_flags_i = d_flags; bif.tcp_win_i = d_win;
        bif.pay_len_i = d_len;
        bif.hdr_valid_i = 1'b1;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bif.hdr_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
            #1;
        end
        check("hdr_accept", 64'(ok), 64'd1);
        @(negedge CLK);
        bif.hdr_valid_i = 1'b0;
    endtask

    task automatic reset_mid();
        bif.pay_valid_i = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_valid", 64'(bif.bus_valid_o), 64'd0);
        check("rst_bus", 64'(bif.bus_o), 64'd0);
        check("rst_sop", 64'(bif.start_of_packet_o), 64'd0);
        check("rst_last", 64'(bif.bus_last_o), 64'd0);
        check("rst_bytes", 64'(bif.bus_bytes_o), 64'd4);
        check("rst_hrdy", 64'(bif.hdr_ready_o), 64'd0);
        check("rst_prdy", 64'(bif.pay_ready_o), 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b1;
    endtask

    // mode 0: sink always ready; 1: ready toggles 1,0; 2: random both sides
    task automatic run_frame(input int mode, input int rst_word);
        int nw, wi, first, budget, c, nsop;
        bit done, pseen, aborted;
        build_exp();
        nw = (int'(d_len) + 3) / 4;
        rx_d.delete(); rx_b.delete(); rx_s.delete(); rx_l.delete();
        wi = 0; first = -1; done = 1'b0; pseen = 1'b0; aborted = 1'b0;
        budget = 4 * nw + 200;
        send_desc();
        for (c = 0; c < budget && !done && !aborted; c++) begin
            if (rst_word >= 0 && wi >= rst_word) begin
                reset_mid();
                aborted = 1'b1;
            end else begin
                bif.bus_ready_i = (mode == 0) ? 1'b1 :
                                  (mode == 1) ? (c % 2 == 0) :
                                  ($urandom_range(0, 3) != 0);
                if (mode != 2 || $urandom_range(0, 3) != 0) begin
                    bif.pay_valid_i = 1'b1;
                    bif.pay_i = (wi < nw) ? words[wi] : $urandom;
                end else begin
                    bif.pay_valid_i = 1'b0;
                    bif.pay_i = $urandom;
                end
                #1;
                if (c == 1) check("hrdy_busy", 64'(bif.hdr_ready_o), 64'd0);
                if (bif.pay_ready_o) pseen = 1'b1;
                if (bif.bus_valid_o && first < 0) first = c;
                if (bif.bus_valid_o && bif.bus_ready_i) begin
                    rx_d.push_back(bif.bus_o);
                    rx_b.push_back(int'(bif.bus_bytes_o));
                    rx_s.push_back(bif.start_of_packet_o);
                    rx_l.push_back(bif.bus_last_o);
                    if (bif.bus_last_o) done = 1'b1;
                end
                if (bif.pay_valid_i && bif.pay_ready_o) wi++;
                @(negedge CLK);
            end
        end
        bif.pay_valid_i = 1'b0;
        if (!aborted) begin
            int nb;
            nb = (exp_q.size() + 3) / 4;
            check("frame_done", 64'(done), 64'd1);
            check("latency", 64'(first), 64'd2);
            check("beats", 64'(rx_d.size()), 64'(nb));
            check("words", 64'(wi), 64'(nw));
            check("prdy_seen", 64'(pseen), 64'(nw > 0));
            nsop = 0;
            for (int k = 0; k < rx_d.size() && k < nb; k++) begin
                logic [31:0] ed, mk;
                int n;
                ed = '0; mk = '0;
                n = exp_q.size() - 4*k;
                if (n > 4) n = 4;
                for (int j = 0; j < n; j++) begin
                    ed[31 - 8*j -: 8] = exp_q[4*k + j];
                    mk[31 - 8*j -: 8] = 8'hff;
                end
                if (rx_s[k]) nsop++;
                check("beat_data", 64'(rx_d[k] & mk), 64'(ed));
                check("beat_bytes", 64'(rx_b[k]), 64'(n));
                check("beat_sop", 64'(rx_s[k]), 64'(k == 0));
                check("beat_last", 64'(rx_l[k]), 64'(k == nb - 1));
            end
            check("sop_count", 64'(nsop), 64'd1);
        end
    endtask

    task automatic err_case(input logic [7:0] proto, input logic [15:0] len);
        rand_desc(proto, len);
        send_desc();
        check("err_pulse", 64'(bif.hdr_err_o), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("err_clear", 64'(bif.hdr_err_o), 64'd0);
            check("err_novalid", 64'(bif.bus_valid_o), 64'd0);
            check("err_idle", 64'(bif.hdr_ready_o), 64'd1);
        end
    endtask

    initial begin
        reset = 1'b0;
        bif.hdr_valid_i = 1'b0;
        bif.pay_valid_i = 1'b0;
        bif.pay_i = '0;
        bif.bus_ready_i = 1'b1;
        rand_desc(8'd17, 16'd0);
        repeat (2) @(negedge CLK);
        check("reset_valid", 64'(bif.bus_valid_o), 64'd0);
        check("reset_bytes", 64'(bif.bus_bytes_o), 64'd4);
        check("reset_hrdy", 64'(bif.hdr_ready_o), 64'd0);
        check("reset_err", 64'(bif.hdr_err_o), 64'd0);
        reset = 1'b1;

        rand_desc(8'h11, 16'd87);
        d_tos = 8'h00; d_id = 16'h0000; d_ttl = 8'h40;
        d_ips = 32'hc0a80001; d_ipd = 32'hc0a800c7;
        run_frame(0, -1);
        check("t1_beats", 64'(rx_d.size()), 64'd33);
        if (rx_d.size() == 33) begin
            check("t1_totlen", 64'(rx_d[4][31:16]), 64'h0073);
            check("t1_csum", 64'(rx_d[6][31:16]), 64'hb861);
            check("t1_udplen", 64'(rx_d[9][15:0]), 64'h005f);
            check("t1_lastbytes", 64'(rx_b[32]), 64'd1);
        end

        rand_desc(8'd6, 16'd8);
        run_frame(0, -1);
        check("t2_beats", 64'(rx_d.size()), 64'd16);
        if (rx_d.size() == 16) begin
            check("t2_etype", 64'(rx_d[3][31:16]), 64'h0800);
            check("t2_doff", 64'(rx_d[11][15:8]), 64'h50);
            check("t2_lastbytes", 64'(rx_b[15]), 64'd2);
        end

        rand_desc(8'd17, 16'd0);
        run_frame(0, -1);
        check("t3_beats", 64'(rx_d.size()), 64'd11);

        rand_desc(8'd17, 16'd5);
        run_frame(1, -1);
        check("t4_beats", 64'(rx_d.size()), 64'd12);

        err_case(8'd1, 16'd10);
        err_case(8'd17, 16'd1500);
        err_case(8'd6, 16'd1473);

        rand_desc(8'd17, 16'd40);
        run_frame(0, 5);
        rand_desc(8'd6, 16'd23);
        run_frame(0, -1);

        for (int i = 0; i < 8; i++) begin
            rand_desc(($urandom_range(0, 1) != 0) ? 8'd6 : 8'd17,
                      16'($urandom_range(0, 70)));
            run_frame(2, -1);
        end

        rand_desc(8'd17, 16'd1472);
        run_frame(2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
